// File: rtl/peak_finder.sv
// peak_finder: threshold-triggered pulse peak extractor with dead time and pile-up counting
module peak_finder #(
  parameter int DATA_WIDTH = 16,
  parameter int TS_WIDTH   = 32,
  parameter int DT_WIDTH   = 8,
  parameter int MAX_LEN    = 256,
  parameter int PU_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] input_data,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  input  logic        [DT_WIDTH-1:0]   dead_time,
  output logic                         peak_valid,
  output logic signed [DATA_WIDTH-1:0] peak_amplitude,
  output logic        [TS_WIDTH-1:0]   peak_time,
  output logic                         peak_timeout,
  output logic                         busy,
  output logic        [PU_WIDTH-1:0]   pileup_count
);
  localparam int LW = $clog2(MAX_LEN);
  localparam logic [LW-1:0] LEN_LAST = LW'(MAX_LEN - 1);
  typedef enum logic [1:0] {IDLE, ARMED, DEAD} state_t;
  state_t state_q, state_d;
  logic [TS_WIDTH-1:0] ts_q, s_ts_q, max_ts_q, max_ts_d, time_q, time_d;
  logic signed [DATA_WIDTH-1:0] s_q, max_q, max_d, thr_q, thr_d, amp_q, amp_d;
  logic [LW-1:0] len_q, len_d;
  logic [DT_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [PU_WIDTH-1:0] pu_q, pu_d;
  logic emit_q, to_q, valid_q, valid_d, tmo_flag_q, tmo_flag_d;
  logic arm, above, grow, tmo, emit;
  assign arm   = state_q == IDLE && s_q > threshold;
  assign above = s_q > thr_q;
  assign grow  = state_q == ARMED && above && s_q > max_q;
  assign tmo   = state_q == ARMED && above && len_q == LEN_LAST;
  assign emit  = (state_q == ARMED && !above) || tmo;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = arm ? ARMED : IDLE;
      ARMED:   state_d = emit ? DEAD : ARMED;
      DEAD:    state_d = dcnt_q == '0 ? IDLE : DEAD;
      default: state_d = IDLE;
    endcase
  end
  // the timeout-cycle sample still competes for the maximum before the emit
  always_comb begin
    max_d      = (arm || grow) ? s_q : max_q;
    max_ts_d   = (arm || grow) ? s_ts_q : max_ts_q;
    len_d      = arm ? LW'(1) : (state_q == ARMED && !emit) ? len_q + LW'(1) : len_q;
    thr_d      = arm ? threshold : thr_q;
    dcnt_d     = emit ? dead_time : (state_q == DEAD && dcnt_q != '0) ? dcnt_q - DT_WIDTH'(1) : dcnt_q;
    pu_d       = (state_q == DEAD && above && pu_q != '1) ? pu_q + PU_WIDTH'(1) : pu_q;
    valid_d    = emit_q;
    amp_d      = emit_q ? max_q : amp_q;
    time_d     = emit_q ? max_ts_q : time_q;
    tmo_flag_d = emit_q ? to_q : tmo_flag_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ts_q       <= '0;
      s_q        <= '0;
      s_ts_q     <= '0;
      max_q      <= '0;
      max_ts_q   <= '0;
      len_q      <= '0;
      thr_q      <= '0;
      dcnt_q     <= '0;
      pu_q       <= '0;
      emit_q     <= 1'b0;
      to_q       <= 1'b0;
      valid_q    <= 1'b0;
      amp_q      <= '0;
      time_q     <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      ts_q       <= ts_q + TS_WIDTH'(1);
      s_q        <= input_data;
      s_ts_q     <= ts_q;
      max_q      <= max_d;
      max_ts_q   <= max_ts_d;
      len_q      <= len_d;
      thr_q      <= thr_d;
      dcnt_q     <= dcnt_d;
      pu_q       <= pu_d;
      emit_q     <= emit;
      to_q       <= tmo;
      valid_q    <= valid_d;
      amp_q      <= amp_d;
      time_q     <= time_d;
      tmo_flag_q <= tmo_flag_d;
    end
  always_comb begin
    peak_valid     = valid_q;
    peak_amplitude = amp_q;
    peak_time      = time_q;
    peak_timeout   = tmo_flag_q;
    busy           = state_q != IDLE;
    pileup_count   = pu_q;
  end
endmodule

// File: tb/tb_peak_finder.sv
// tb_peak_finder: directed pulses into a long-window and a short-window/narrow-timestamp peak_finder
module tb_peak_finder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [15:0] input_data = '0;
  logic signed [15:0] threshold = 16'sd100;
  logic [7:0] dead_time = 8'd4;
  logic [1:0] pv, pto, bz;
  logic [1:0][15:0] pa;
  logic [1:0][7:0] pu;
  logic [31:0] pt_a;
  logic [7:0] pt_b;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  peak_finder #(.DATA_WIDTH(16), .TS_WIDTH(32), .DT_WIDTH(8), .MAX_LEN(256), .PU_WIDTH(8)) u_a (
    .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold), .dead_time(dead_time),
    .peak_valid(pv[0]), .peak_amplitude(pa[0]), .peak_time(pt_a), .peak_timeout(pto[0]),
    .busy(bz[0]), .pileup_count(pu[0]));
  peak_finder #(.DATA_WIDTH(16), .TS_WIDTH(8), .DT_WIDTH(8), .MAX_LEN(4), .PU_WIDTH(8)) u_b (
    .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold), .dead_time(dead_time),
    .peak_valid(pv[1]), .peak_amplitude(pa[1]), .peak_time(pt_b), .peak_timeout(pto[1]),
    .busy(bz[1]), .pileup_count(pu[1]));
  // model: mode 0 waiting, 1 collecting a pulse into a buffer, 2 dead
  int maxlen[2] = '{256, 4};
  longint mask[2] = '{64'hFFFF_FFFF, 64'hFF};
  int md[2], n[2], thrq[2], dleft[2], pile[2], prev_v[2];
  longint prev_t[2], cnt[2];
  int bufv[2][256];
  longint buft[2][256];
  bit pend[2], pend_to[2];
  int pend_amp[2];
  longint pend_t[2];
  bit e_valid[2], e_to[2], e_busy[2];
  int e_amp[2], e_pile[2];
  longint e_t[2];
  int log_amp[2][16];
  longint log_t[2][16];
  bit log_to[2][16];
  int nlog[2] = '{0, 0};
  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      md[m] = 0; n[m] = 0; thrq[m] = 0; dleft[m] = 0; pile[m] = 0; prev_v[m] = 0;
      prev_t[m] = 0; cnt[m] = 0; pend[m] = 0; pend_to[m] = 0; pend_amp[m] = 0; pend_t[m] = 0;
      e_valid[m] = 0; e_to[m] = 0; e_busy[m] = 0; e_amp[m] = 0; e_pile[m] = 0; e_t[m] = 0;
    end
  endtask
  task automatic finish_pulse(input int m, input bit to);
    int best = 0;
    for (int i = 1; i < n[m]; i++) if (bufv[m][i] > bufv[m][best]) best = i;
    pend[m] = 1; pend_amp[m] = bufv[m][best]; pend_t[m] = buft[m][best]; pend_to[m] = to;
    md[m] = 2; dleft[m] = int'(dead_time);
  endtask
  task automatic append(input int m, input int s, input longint st);
    bufv[m][n[m]] = s; buft[m][n[m]] = st; n[m]++;
  endtask
  task automatic model_step(input int m);
    int s = prev_v[m];
    longint st = prev_t[m];
    e_valid[m] = pend[m];
    if (pend[m]) begin
      e_amp[m] = pend_amp[m]; e_t[m] = pend_t[m]; e_to[m] = pend_to[m];
      if (nlog[m] < 16) begin
        log_amp[m][nlog[m]] = pend_amp[m]; log_t[m][nlog[m]] = pend_t[m]; log_to[m][nlog[m]] = pend_to[m];
      end
      nlog[m]++;
      pend[m] = 0;
    end
    if (md[m] == 0) begin
      if (s > int'(threshold)) begin
        n[m] = 0; append(m, s, st); thrq[m] = int'(threshold); md[m] = 1;
      end
    end else if (md[m] == 1) begin
      if (s <= thrq[m]) finish_pulse(m, 0);
      else if (n[m] == maxlen[m] - 1) begin append(m, s, st); finish_pulse(m, 1); end
      else append(m, s, st);
    end else begin
      if (s > thrq[m] && pile[m] < 255) pile[m]++;
      if (dleft[m] == 0) md[m] = 0; else dleft[m]--;
    end
    prev_v[m] = int'(input_data);
    prev_t[m] = cnt[m] & mask[m];
    cnt[m]++;
    e_busy[m] = md[m] != 0;
    e_pile[m] = pile[m];
  endtask
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else for (int m = 0; m < 2; m++) model_step(m);
    end
  end
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic check_inst(input int m, input logic av, input logic signed [15:0] aa,
                            input logic [31:0] at, input logic ato, input logic abz, input logic [7:0] apu);
    chk($sformatf("u%0d.valid", m), av, e_valid[m]);
    chk($sformatf("u%0d.amp", m), aa, e_amp[m]);
    chk($sformatf("u%0d.time", m), at, e_t[m]);
    chk($sformatf("u%0d.timeout", m), ato, e_to[m]);
    chk($sformatf("u%0d.busy", m), abz, e_busy[m]);
    chk($sformatf("u%0d.pileup", m), apu, e_pile[m]);
  endtask
  initial forever begin
    @(negedge clk);
    check_inst(0, pv[0], pa[0], pt_a, pto[0], bz[0], pu[0]);
    check_inst(1, pv[1], pa[1], {24'b0, pt_b}, pto[1], bz[1], pu[1]);
  end
  task automatic put(input int v);
    input_data = 16'(v);
    @(negedge clk);
  endtask
  task automatic puts(input int v, input int k);
    for (int i = 0; i < k; i++) put(v);
  endtask
  int ea_amp[7] = '{300, 400, 300, 200, -5, 300, 300};
  longint ea_t[7] = '{3, 17, 32, 47, 69, 3, 255};
  int eb_amp[8] = '{300, 400, 300, 200, 200, -5, 300, 300};
  longint eb_t[8] = '{3, 17, 32, 47, 56, 69, 3, 255};
  bit eb_to[8] = '{1, 1, 1, 1, 0, 0, 1, 0};
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    put(0); put(50); put(150); put(300); put(250); put(120); put(80);
    put(0);
    chk("t1.valid_early", pv[0], 0);
    put(0);
    chk("t1.valid_lat", pv[0], 1);
    chk("t1.amp_lit", $signed(pa[0]), 300);
    chk("t1.time_lit", pt_a, 3);
    chk("t1.timeout_lit", pto[0], 0);
    puts(0, 6);
    chk("t1.pileup_lit", pu[0], 0);
    put(0); put(200); puts(400, 3); put(50); puts(0, 8);
    put(0); put(50); put(150); put(300); put(250); put(120); put(80); put(500); puts(0, 10);
    chk("t3.pileup_a", pu[0], 1);
    chk("t3.pileup_b", pu[1], 1);
    puts(200, 10); puts(0, 10);
    chk("t4.pileup_b", pu[1], 6);
    chk("t4.timeout_b_hold", pto[1], 0);
    put(-20);
    threshold = -16'sd10;
    put(-10); put(-5); put(-10); puts(-20, 10);
    chk("t5.amp_lit", $signed(pa[0]), -5);
    threshold = 16'sd100;
    put(0); put(150); put(300); put(300); put(300);
    #2 reset = 1'b1;
    #1;
    chk("t6.busy_rst", bz[0], 0);
    chk("t6.amp_rst", $signed(pa[0]), 0);
    chk("t6.pileup_rst", pu[0], 0);
    chk("t6.valid_rst", pv[0], 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    put(0); put(50); put(150); put(300); put(250); put(120); put(80);
    puts(0, 247);
    put(150); put(300); put(50); puts(0, 12);
    chk("wrap.time_b", pt_b, 255);
    chk("a.emits", nlog[0], 7);
    chk("b.emits", nlog[1], 8);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("a.log%0d.amp", i), log_amp[0][i], ea_amp[i]);
      chk($sformatf("a.log%0d.time", i), log_t[0][i], ea_t[i]);
      chk($sformatf("a.log%0d.to", i), log_to[0][i], 0);
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b.log%0d.amp", i), log_amp[1][i], eb_amp[i]);
      chk($sformatf("b.log%0d.time", i), log_t[1][i], eb_t[i]);
      chk($sformatf("b.log%0d.to", i), log_to[1][i], eb_to[i]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
